// File: rtl/uart_proto_pkg.sv
// Shared protocol constants for the UART command initiator: header/PID bytes,
// CRC-16 parameters, error bit positions and the initiator state encoding.
package uart_proto_pkg;

    localparam logic [7:0] HDR1        = 8'h8F;
    localparam logic [7:0] HDR0        = 8'hC7;
    localparam logic [7:0] PID1_BURST  = 8'h80;
    localparam logic [7:0] PID1_SINGLE = 8'h00;
    localparam logic [7:0] PID0_RD     = 8'h02;
    localparam logic [7:0] PID0_WR     = 8'h01;

    localparam logic [15:0] CRC_POLY = 16'h8005;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    localparam int unsigned ERR_LEN = 2;
    localparam int unsigned ERR_TMO = 1;
    localparam int unsigned ERR_CRC = 0;

    typedef enum logic [4:0] {
        S_IDLE, S_HDR1, S_HDR0, S_PID1, S_PID0, S_LEN1, S_LEN0, S_ADR1, S_ADR0,
        S_WD_REQ, S_WD_WAIT, S_WD1, S_WD0, S_WCRC1, S_WCRC0,
        S_RD1, S_RD0, S_RCRC1, S_RCRC0, S_DONE
    } state_e;

    // MSB-first CRC-16 update over one byte, no reflection.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] din);
        logic [15:0] c;
        c = crc ^ {din, 8'h00};
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/uart_cmd_init_hs_crc.sv
// Registered CRC-16 engine, one byte per enabled cycle; clear wins over init and update.
module uart_cmd_init_hs_crc
    import uart_proto_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        init_i,
    input  logic        en_i,
    input  logic [7:0]  data_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            crc_q <= '0;
        end else if (init_i) begin
            crc_q <= CRC_INIT;
        end else if (en_i) begin
            crc_q <= crc16_byte(crc_q, data_i);
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/uart_cmd_init_hs.sv
// UART command initiator: frames host read/write commands into bytes with CRC-16.
// Define UART_CMD_INIT_CRC_CHK_EN to check the received read CRC (err[0]).
module uart_cmd_init_hs
    import uart_proto_pkg::*;
#(
    parameter int unsigned P_TIMEOUT_CNT_MAX = 125_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_req,
    output logic        cmd_ack,
    input  logic        cmd_rd,
    input  logic        cmd_burst,
    input  logic [15:0] cmd_len,
    input  logic [11:0] cmd_adr,
    output logic        wd_rdreq,
    input  logic [15:0] wd_data,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        done,
    output logic [2:0]  err,
    output logic        tx_req,
    output logic [7:0]  tx_data,
    input  logic        tx_ack,
    input  logic        rx_req,
    input  logic [7:0]  rx_data,
    output logic        rx_ack
);

    state_e      state_q, nxt_state;
    logic [15:0] cnt_q, len_q, word_q, crc;
    logic [31:0] to_cnt_q;
    logic [11:0] adr_q;
    logic [7:0]  rd_hi_q, rx_byte_q, tx_byte, tx_data_q, crc_din;
    logic [2:0]  err_q;
    logic        rd_q, burst_q, tx_ph_q, tx_req_q, rx_ack_q;
    logic        cmd_ack_q, wd_rdreq_q, rd_valid_q, done_q;
    logic [15:0] rd_data_q;
    logic        is_tx, is_rx, tx_done, rx_done, accept, tmo, crc_en;
`ifdef UART_CMD_INIT_CRC_CHK_EN
    logic [7:0]  rcrc_hi_q;
`endif

    always_comb begin
        tx_byte   = '0;
        nxt_state = S_IDLE;
        case (state_q)
            S_HDR1:  begin tx_byte = HDR1; nxt_state = S_HDR0; end
            S_HDR0:  begin tx_byte = HDR0; nxt_state = S_PID1; end
            S_PID1:  begin tx_byte = burst_q ? PID1_BURST : PID1_SINGLE; nxt_state = S_PID0; end
            S_PID0:  begin tx_byte = rd_q ? PID0_RD : PID0_WR; nxt_state = burst_q ? S_LEN1 : S_ADR1; end
            S_LEN1:  begin tx_byte = len_q[15:8]; nxt_state = S_LEN0; end
            S_LEN0:  begin tx_byte = len_q[7:0]; nxt_state = S_ADR1; end
            S_ADR1:  begin tx_byte = {4'h0, adr_q[11:8]}; nxt_state = S_ADR0; end
            S_ADR0:  begin tx_byte = adr_q[7:0]; nxt_state = rd_q ? S_RD1 : S_WD_REQ; end
            S_WD1:   begin tx_byte = wd_data[15:8]; nxt_state = S_WD0; end
            S_WD0:   begin tx_byte = word_q[7:0]; nxt_state = (cnt_q == 16'd1) ? S_WCRC1 : S_WD_REQ; end
            S_WCRC1: begin tx_byte = crc[15:8]; nxt_state = S_WCRC0; end
            S_WCRC0: begin tx_byte = crc[7:0]; nxt_state = S_DONE; end
            S_RD1:   nxt_state = S_RD0;
            S_RD0:   nxt_state = (cnt_q == 16'd1) ? S_RCRC1 : S_RD1;
            S_RCRC1: nxt_state = S_RCRC0;
            S_RCRC0: nxt_state = S_DONE;
            default: nxt_state = S_IDLE;
        endcase
    end

    assign is_tx   = state_q inside {S_HDR1, S_HDR0, S_PID1, S_PID0, S_LEN1, S_LEN0,
                                     S_ADR1, S_ADR0, S_WD1, S_WD0, S_WCRC1, S_WCRC0};
    assign is_rx   = state_q inside {S_RD1, S_RD0, S_RCRC1, S_RCRC0};
    assign tx_done = is_tx && tx_ph_q && !tx_ack;
    assign rx_done = is_rx && rx_ack_q && !rx_req;
    assign accept  = (state_q == S_IDLE) && cmd_req;
    assign tmo     = (state_q != S_IDLE) && (to_cnt_q == P_TIMEOUT_CNT_MAX);
    assign crc_en  = (tx_done && (state_q inside {S_ADR1, S_ADR0, S_WD1, S_WD0})) ||
                     (rx_done && (state_q inside {S_RD1, S_RD0}));
    assign crc_din = is_tx ? tx_data_q : rx_byte_q;

    uart_cmd_init_hs_crc u_crc (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (tmo),
        .init_i (accept),
        .en_i   (crc_en),
        .data_i (crc_din),
        .crc_o  (crc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            {cnt_q, len_q, word_q, to_cnt_q, adr_q, rd_hi_q, rx_byte_q} <= '0;
            {rd_q, burst_q, tx_ph_q, tx_req_q, tx_data_q, rx_ack_q, err_q} <= '0;
            {cmd_ack_q, wd_rdreq_q, rd_data_q, rd_valid_q, done_q} <= '0;
`ifdef UART_CMD_INIT_CRC_CHK_EN
            rcrc_hi_q <= '0;
`endif
        end else begin
            cmd_ack_q  <= 1'b0;
            wd_rdreq_q <= 1'b0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            to_cnt_q   <= (state_q == S_IDLE) ? '0 : to_cnt_q + 32'd1;
            if (tmo) begin
                state_q          <= S_DONE;
                to_cnt_q         <= '0;
                err_q[ERR_TMO]   <= 1'b1;
                tx_req_q         <= 1'b0;
                tx_ph_q          <= 1'b0;
                rx_ack_q         <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: if (cmd_req) begin
                        cmd_ack_q <= 1'b1;
                        rd_q      <= cmd_rd;
                        burst_q   <= cmd_burst;
                        len_q     <= cmd_len;
                        adr_q     <= cmd_adr;
                        cnt_q     <= cmd_burst ? cmd_len : 16'd1;
                        err_q     <= '0;
                        if (cmd_burst && cmd_len == 16'd0) begin
                            err_q[ERR_LEN] <= 1'b1;
                            state_q        <= S_DONE;
                        end else begin
                            state_q <= S_HDR1;
                        end
                    end
                    S_WD_REQ: begin
                        wd_rdreq_q <= 1'b1;
                        state_q    <= S_WD_WAIT;
                        to_cnt_q   <= '0;
                    end
                    S_WD_WAIT: begin
                        state_q  <= S_WD1;
                        to_cnt_q <= '0;
                    end
                    S_DONE: begin
                        done_q   <= 1'b1;
                        state_q  <= S_IDLE;
                        to_cnt_q <= '0;
                    end
                    default: begin
                        // tx_data is loaded once per byte so it stays stable through the handshake
                        if (is_tx) begin
                            if (!tx_ph_q && !tx_req_q) begin
                                tx_req_q  <= 1'b1;
                                tx_data_q <= tx_byte;
                                if (state_q == S_WD1) word_q <= wd_data;
                            end else if (!tx_ph_q && tx_ack) begin
                                tx_req_q <= 1'b0;
                                tx_ph_q  <= 1'b1;
                            end else if (tx_done) begin
                                tx_ph_q  <= 1'b0;
                                state_q  <= nxt_state;
                                to_cnt_q <= '0;
                                if (state_q == S_WD0) cnt_q <= cnt_q - 16'd1;
                            end
                        end else if (is_rx) begin
                            if (!rx_ack_q && rx_req) begin
                                rx_ack_q  <= 1'b1;
                                rx_byte_q <= rx_data;
                            end else if (rx_done) begin
                                rx_ack_q <= 1'b0;
                                state_q  <= nxt_state;
                                to_cnt_q <= '0;
                                case (state_q)
                                    S_RD1: rd_hi_q <= rx_byte_q;
                                    S_RD0: begin
                                        rd_data_q  <= {rd_hi_q, rx_byte_q};
                                        rd_valid_q <= 1'b1;
                                        cnt_q      <= cnt_q - 16'd1;
                                    end
`ifdef UART_CMD_INIT_CRC_CHK_EN
                                    S_RCRC1: rcrc_hi_q <= rx_byte_q;
                                    S_RCRC0: if ({rcrc_hi_q, rx_byte_q} != crc) err_q[ERR_CRC] <= 1'b1;
`endif
                                    default: ;
                                endcase
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign cmd_ack  = cmd_ack_q;
    assign wd_rdreq = wd_rdreq_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign done     = done_q;
    assign err      = err_q;
    assign tx_req   = tx_req_q;
    assign tx_data  = tx_data_q;
    assign rx_ack   = rx_ack_q;

endmodule

// File: tb/tb_uart_cmd_init_hs.sv
// Scoreboard bench for uart_cmd_init_hs: phy/FIFO responders plus an output monitor
// comparing against queued expectations.
module tb_uart_cmd_init_hs;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_req = 1'b0, cmd_rd = 1'b0, cmd_burst = 1'b0;
    logic [15:0] cmd_len = '0;
    logic [11:0] cmd_adr = '0;
    logic        cmd_ack, wd_rdreq, rd_valid, done, tx_req, rx_ack;
    logic [15:0] wd_data = '0, rd_data;
    logic [2:0]  err;
    logic [7:0]  tx_data, rx_data = '0;
    logic        tx_ack = 1'b0, rx_req = 1'b0;

    uart_cmd_init_hs #(.P_TIMEOUT_CNT_MAX(1000)) dut (
        .clk(clk), .rst(rst), .cmd_req(cmd_req), .cmd_ack(cmd_ack), .cmd_rd(cmd_rd),
        .cmd_burst(cmd_burst), .cmd_len(cmd_len), .cmd_adr(cmd_adr), .wd_rdreq(wd_rdreq),
        .wd_data(wd_data), .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
        .tx_req(tx_req), .tx_data(tx_data), .tx_ack(tx_ack), .rx_req(rx_req),
        .rx_data(rx_data), .rx_ack(rx_ack)
    );

    always #5 clk = ~clk;

    int unsigned tests = 0, fails = 0;
    int unsigned cyc = 0, ack_cnt = 0, done_cnt = 0, tx_cnt = 0, rdreq_cnt = 0;
    int unsigned last_ack_cyc = 0, last_done_cyc = 0, last_rdv_cyc = 0;
    bit          tx_req_seen = 1'b0;
    logic [7:0]  exp_tx[$];
    logic [7:0]  rx_src[$];
    logic [15:0] exp_rd[$];
    logic [15:0] wd_src[$];
    logic [2:0]  exp_done[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] crc_of(input logic [63:0] bytes, input int unsigned n);
        logic [15:0] c;
        logic [7:0]  b;
        logic        fb;
        c = 16'hFFFF;
        for (int unsigned i = 0; i < n; i++) begin
            b = bytes[8*(n-1-i) +: 8];
            for (int j = 7; j >= 0; j--) begin
                fb = c[15] ^ b[j];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h8005;
            end
        end
        return c;
    endfunction

    // Output monitor
    initial forever begin
        @(posedge clk); #1;
        cyc++;
        if (cmd_ack) begin ack_cnt++; last_ack_cyc = cyc; end
        if (tx_req) tx_req_seen = 1'b1;
        if (rd_valid) begin
            last_rdv_cyc = cyc;
            if (exp_rd.size() == 0) check("rd_valid_unexpected", rd_valid, 0);
            else check("rd_data", rd_data, exp_rd.pop_front());
        end
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
            if (exp_done.size() == 0) check("done_unexpected", done, 0);
            else check("done_err", err, exp_done.pop_front());
        end
    end

    // TX phy responder
    initial forever begin
        @(negedge clk);
        if (rst) tx_ack = 1'b0;
        else if (tx_req && !tx_ack) begin
            tx_cnt++;
            if (exp_tx.size() == 0) check("tx_req_unexpected", tx_req, 0);
            else check("tx_byte", tx_data, exp_tx.pop_front());
            tx_ack = 1'b1;
        end else if (!tx_req && tx_ack) tx_ack = 1'b0;
    end

    // RX phy responder
    initial forever begin
        @(negedge clk);
        if (rst) rx_req = 1'b0;
        else if (!rx_req && !rx_ack && rx_src.size() > 0) begin
            rx_data = rx_src.pop_front();
            rx_req  = 1'b1;
        end else if (rx_req && rx_ack) rx_req = 1'b0;
    end

    // Write-data FIFO
    initial forever begin
        @(negedge clk);
        if (wd_rdreq) begin
            rdreq_cnt++;
            if (wd_src.size() == 0) check("wd_rdreq_unexpected", wd_rdreq, 0);
            else wd_data = wd_src.pop_front();
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_cmd(input logic rd, input logic burst, input logic [15:0] len, input logic [11:0] adr);
        int unsigned a0, n;
        a0 = ack_cnt;
        n  = 0;
        @(negedge clk);
        cmd_rd = rd; cmd_burst = burst; cmd_len = len; cmd_adr = adr; cmd_req = 1'b1;
        while (ack_cnt == a0 && n < 50) begin @(negedge clk); n++; end
        cmd_req = 1'b0;
        if (ack_cnt == a0) check("cmd_ack_timeout", ack_cnt - a0, 1);
    endtask

    task automatic run_cmd(input logic rd, input logic burst, input logic [15:0] len,
                           input logic [11:0] adr, input int unsigned budget);
        int unsigned d0, n;
        d0 = done_cnt;
        n  = 0;
        send_cmd(rd, burst, len, adr);
        while (done_cnt == d0 && n < budget) begin @(negedge clk); n++; end
        if (done_cnt == d0) check("done_timeout", done_cnt - d0, 1);
        repeat (2) @(negedge clk);
    endtask

    logic [15:0] c;
    int unsigned r0, t0, a0, d0, first_done, n;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs", {cmd_ack, wd_rdreq, rd_data, rd_valid, done, err, tx_req, tx_data, rx_ack}, 0);
        rst = 1'b0;
        @(negedge clk);

        // single write 0x123 <- 0xABCD; len field ignored for single
        c = crc_of(64'h0123ABCD, 4);
        wd_src = '{16'hABCD};
        exp_tx = '{8'h8F, 8'hC7, 8'h00, 8'h01, 8'h01, 8'h23, 8'hAB, 8'hCD, c[15:8], c[7:0]};
        exp_done = '{3'b000};
        r0 = rdreq_cnt;
        run_cmd(1'b0, 1'b0, 16'h0005, 12'h123, 500);
        check("t1_rdreq_count", rdreq_cnt - r0, 1);
        check("t1_tx_left", exp_tx.size(), 0);

        // burst read len 3 at 0x0FE, good CRC
        c = crc_of(64'h00FE000100020003, 8);
        exp_tx = '{8'h8F, 8'hC7, 8'h80, 8'h02, 8'h00, 8'h03, 8'h00, 8'hFE};
        rx_src = '{8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, c[15:8], c[7:0]};
        exp_rd = '{16'h0001, 16'h0002, 16'h0003};
        exp_done = '{3'b000};
        run_cmd(1'b1, 1'b1, 16'd3, 12'h0FE, 800);
        check("t2_rd_left", exp_rd.size(), 0);

        // same read with the CRC lo byte corrupted
        exp_tx = '{8'h8F, 8'hC7, 8'h80, 8'h02, 8'h00, 8'h03, 8'h00, 8'hFE};
        rx_src = '{8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, c[15:8], c[7:0] ^ 8'h01};
        exp_rd = '{16'h0001, 16'h0002, 16'h0003};
`ifdef UART_CMD_INIT_CRC_CHK_EN
        exp_done = '{3'b001};
`else
        exp_done = '{3'b000};
`endif
        run_cmd(1'b1, 1'b1, 16'd3, 12'h0FE, 800);

        // burst write with zero length: no bytes, length error
        tx_req_seen = 1'b0;
        t0 = tx_cnt;
        exp_done = '{3'b100};
        run_cmd(1'b0, 1'b1, 16'd0, 12'h055, 50);
        check("t4_no_tx_req", tx_req_seen, 0);
        check("t4_no_tx_bytes", tx_cnt - t0, 0);

        // burst write len 2 with a second request held while busy
        c = crc_of(64'h0A5C1234BEEF, 6);
        wd_src = '{16'h1234, 16'hBEEF};
        exp_tx = '{8'h8F, 8'hC7, 8'h80, 8'h01, 8'h00, 8'h02, 8'h0A, 8'h5C,
                   8'h12, 8'h34, 8'hBE, 8'hEF, c[15:8], c[7:0]};
        exp_done = '{3'b000, 3'b100};
        a0 = ack_cnt; d0 = done_cnt; first_done = 0; n = 0;
        send_cmd(1'b0, 1'b1, 16'd2, 12'hA5C);
        cmd_burst = 1'b1; cmd_rd = 1'b0; cmd_len = 16'd0; cmd_req = 1'b1;
        while (done_cnt < d0 + 2 && n < 1000) begin
            @(negedge clk); n++;
            if (done_cnt == d0 + 1 && first_done == 0) first_done = last_done_cyc;
            if (ack_cnt > a0 + 1) cmd_req = 1'b0;
        end
        cmd_req = 1'b0;
        check("t5_done_count", done_cnt - d0, 2);
        check("t5_ack_count", ack_cnt - a0, 2);
        check("t5_busy_req_deferred", (first_done != 0) && (last_ack_cyc > first_done), 1);
        repeat (2) @(negedge clk);

        // single read, responder stalls after the data word -> timeout
        exp_tx = '{8'h8F, 8'hC7, 8'h00, 8'h02, 8'h00, 8'h10};
        rx_src = '{8'h5A, 8'h3C};
        exp_rd = '{16'h5A3C};
        exp_done = '{3'b010};
        run_cmd(1'b1, 1'b0, 16'd1, 12'h010, 3000);
        check("t6_timeout_latency", (last_done_cyc - last_rdv_cyc >= 990) && (last_done_cyc - last_rdv_cyc <= 1010), 1);
        check("t6_hs_dropped", {tx_req, rx_ack}, 0);

        // normal single write after the timeout
        c = crc_of(64'h03FF0000, 4);
        wd_src = '{16'h0000};
        exp_tx = '{8'h8F, 8'hC7, 8'h00, 8'h01, 8'h03, 8'hFF, 8'h00, 8'h00, c[15:8], c[7:0]};
        exp_done = '{3'b000};
        run_cmd(1'b0, 1'b0, 16'd1, 12'h3FF, 500);

        // reset in the middle of a burst write
        wd_src = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        exp_tx = '{8'h8F, 8'hC7, 8'h80, 8'h01, 8'h00, 8'h04, 8'h02, 8'h00, 8'h11, 8'h11};
        t0 = tx_cnt; n = 0;
        send_cmd(1'b0, 1'b1, 16'd4, 12'h200);
        while (tx_cnt - t0 < 7 && n < 500) begin @(negedge clk); n++; end
        check("t8_reached_mid_write", tx_cnt - t0 >= 7, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("t8_reset_outputs", {cmd_ack, wd_rdreq, rd_data, rd_valid, done, err, tx_req, tx_data, rx_ack}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_tx.delete(); wd_src.delete();
        d0 = done_cnt;
        repeat (50) @(negedge clk);
        check("t8_no_done", done_cnt - d0, 0);

        // recovery: single read of 0xFFFF at 0x7FF
        c = crc_of(64'h07FFFFFF, 4);
        exp_tx = '{8'h8F, 8'hC7, 8'h00, 8'h02, 8'h07, 8'hFF};
        rx_src = '{8'hFF, 8'hFF, c[15:8], c[7:0]};
        exp_rd = '{16'hFFFF};
        exp_done = '{3'b000};
        run_cmd(1'b1, 1'b0, 16'd1, 12'h7FF, 500);

        check("end_exp_tx_empty", exp_tx.size(), 0);
        check("end_exp_rd_empty", exp_rd.size(), 0);
        check("end_exp_done_empty", exp_done.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
